// File: rtl/sync_fifo_pkg.sv
// Shared constants and operation decode for the synchronous FIFO.
`timescale 1ns/1ps
package sync_fifo_pkg;

    localparam int ADR_BIT = 6;
    localparam int DAT_BIT = 32;
    localparam int WEN_BIT = 1;
    localparam int DEPTH   = 2 ** ADR_BIT;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2
    } op_e;

    // Requests that would overflow or underflow collapse to idle.
    function automatic op_e decode_op(input logic cs_any, input logic wr_any,
                                      input logic full, input logic empty);
        op_e op;
        op = OP_IDLE;
        if (cs_any && wr_any && !full) begin
            op = OP_PUSH;
        end else if (cs_any && !wr_any && !empty) begin
            op = OP_POP;
        end else begin
            op = OP_IDLE;
        end
        return op;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port and one registered read port.
`timescale 1ns/1ps
module sync_fifo_mem #(
    parameter int ADR_BIT = sync_fifo_pkg::ADR_BIT,
    parameter int DAT_BIT = sync_fifo_pkg::DAT_BIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [ADR_BIT-1:0] waddr_i,
    input  logic [DAT_BIT-1:0] wdata_i,
    input  logic               re_i,
    input  logic [ADR_BIT-1:0] raddr_i,
    output logic [DAT_BIT-1:0] rdata_o
);

    logic [DAT_BIT-1:0] mem_q [2**ADR_BIT];
    logic [DAT_BIT-1:0] rdata_q;

    // Storage array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read data register holds its value between pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= {DAT_BIT{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO: pointers, occupancy count and flags around sync_fifo_mem.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int ADR_BIT = sync_fifo_pkg::ADR_BIT,
    parameter int DAT_BIT = sync_fifo_pkg::DAT_BIT,
    parameter int WEN_BIT = sync_fifo_pkg::WEN_BIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WEN_BIT-1:0] cs_en,
    input  logic [WEN_BIT-1:0] wr_en,
    input  logic [DAT_BIT-1:0] wr_dat,
    output logic [DAT_BIT-1:0] rd_dat,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic [ADR_BIT:0]   fifo_count
);

    localparam int DEPTH = 2 ** ADR_BIT;

    logic [ADR_BIT-1:0] wptr_q, wptr_d;
    logic [ADR_BIT-1:0] rptr_q, rptr_d;
    logic [ADR_BIT:0]   count_q, count_d;
    logic               full_s, empty_s;
    logic               push_s, pop_s;
    sync_fifo_pkg::op_e op_s;

    assign full_s  = (count_q == (ADR_BIT+1)'(DEPTH));
    assign empty_s = (count_q == {(ADR_BIT+1){1'b0}});
    assign op_s    = sync_fifo_pkg::decode_op(|cs_en, |wr_en, full_s, empty_s);
    assign push_s  = (op_s == sync_fifo_pkg::OP_PUSH) && !rst;
    assign pop_s   = (op_s == sync_fifo_pkg::OP_POP) && !rst;

    // Next-state for pointers and count; pointers wrap naturally at DEPTH.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        case (op_s)
            sync_fifo_pkg::OP_PUSH: begin
                wptr_d  = wptr_q + ADR_BIT'(1);
                count_d = count_q + (ADR_BIT+1)'(1);
            end
            sync_fifo_pkg::OP_POP: begin
                rptr_d  = rptr_q + ADR_BIT'(1);
                count_d = count_q - (ADR_BIT+1)'(1);
            end
            default: begin
                wptr_d  = wptr_q;
                rptr_d  = rptr_q;
                count_d = count_q;
            end
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= {ADR_BIT{1'b0}};
            rptr_q  <= {ADR_BIT{1'b0}};
            count_q <= {(ADR_BIT+1){1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    sync_fifo_mem #(
        .ADR_BIT (ADR_BIT),
        .DAT_BIT (DAT_BIT)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (push_s),
        .waddr_i (wptr_q),
        .wdata_i (wr_dat),
        .re_i    (pop_s),
        .raddr_i (rptr_q),
        .rdata_o (rd_dat)
    );

    assign fifo_full  = full_s;
    assign fifo_empty = empty_s;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: vector table, directed corner sequences, random vs queue model.
`timescale 1ns/1ps
module tb_sync_fifo;

    localparam real CLK_PERIOD = 3.33;
    localparam int  ADR_BIT = 6;
    localparam int  DAT_BIT = 32;
    localparam int  WEN_BIT = 1;
    localparam int  DEPTH   = 2 ** ADR_BIT;

    logic               clk;
    logic               rst;
    logic [WEN_BIT-1:0] cs_en;
    logic [WEN_BIT-1:0] wr_en;
    logic [DAT_BIT-1:0] wr_dat;
    logic [DAT_BIT-1:0] rd_dat;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ADR_BIT:0]   fifo_count;

    int checks = 0;
    int errors = 0;

    logic [DAT_BIT-1:0] model_q[$];
    logic [DAT_BIT-1:0] model_rd;

    typedef struct {
        logic        rst;
        logic        cs;
        logic        wr;
        logic [31:0] dat;
        int          exp_count;
        logic        exp_empty;
        logic        exp_full;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    sync_fifo #(
        .ADR_BIT (ADR_BIT),
        .DAT_BIT (DAT_BIT),
        .WEN_BIT (WEN_BIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cs_en      (cs_en),
        .wr_en      (wr_en),
        .wr_dat     (wr_dat),
        .rd_dat     (rd_dat),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #(CLK_PERIOD / 2.0) clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one request at a negedge, let the posedge act, check at the next negedge.
    task automatic cyc(input logic r, input logic c, input logic w, input logic [31:0] d);
        rst    = r;
        cs_en  = c;
        wr_en  = w;
        wr_dat = d;
        @(negedge clk);
        if (r) begin
            model_q.delete();
            model_rd = '0;
        end else if (c && w && model_q.size() < DEPTH) begin
            model_q.push_back(d);
        end else if (c && !w && model_q.size() > 0) begin
            model_rd = model_q.pop_front();
        end
        chk("model_count", 64'(fifo_count), 64'(model_q.size()));
        chk("model_empty", 64'(fifo_empty), 64'(model_q.size() == 0));
        chk("model_full",  64'(fifo_full),  64'(model_q.size() == DEPTH));
        chk("model_rd",    64'(rd_dat),     64'(model_rd));
    endtask

    initial begin
        rst = 1'b1; cs_en = '0; wr_en = '0; wr_dat = '0;
        model_rd = '0;
        @(negedge clk);
        @(negedge clk);

        // Vector table: {rst, cs, wr, dat, count, empty, full, rd}
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,  0, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h11, 1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h22, 2, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h99, 2, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,  1, 1'b0, 1'b0, 32'h11});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,  1, 1'b0, 1'b0, 32'h11});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,  0, 1'b1, 1'b0, 32'h22});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,  0, 1'b1, 1'b0, 32'h22});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h33, 1, 1'b0, 1'b0, 32'h22});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h44, 0, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,  0, 1'b1, 1'b0, 32'h0});
        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].cs, vecs[i].wr, vecs[i].dat);
            chk($sformatf("vec%0d_count", i), 64'(fifo_count), 64'(vecs[i].exp_count));
            chk($sformatf("vec%0d_empty", i), 64'(fifo_empty), 64'(vecs[i].exp_empty));
            chk($sformatf("vec%0d_full", i),  64'(fifo_full),  64'(vecs[i].exp_full));
            chk($sformatf("vec%0d_rd", i),    64'(rd_dat),     64'(vecs[i].exp_rd));
        end

        // Fill to full, then one ignored write.
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 32'(i));
            chk("fill_count", 64'(fifo_count), 64'(i + 1));
            chk("fill_full",  64'(fifo_full),  64'(i == DEPTH - 1));
        end
        cyc(1'b0, 1'b1, 1'b1, 32'(DEPTH));
        chk("over_count", 64'(fifo_count), 64'(DEPTH));
        chk("over_full",  64'(fifo_full),  64'(1));

        // Drain in order, then reads on empty hold the last word.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            chk("drain_rd", 64'(rd_dat), 64'(i));
        end
        chk("drain_empty", 64'(fifo_empty), 64'(1));
        chk("drain_count", 64'(fifo_count), 64'(0));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            chk("under_rd", 64'(rd_dat), 64'(DEPTH - 1));
        end

        // Wrap: 40 in / 40 out twice crosses pointer wrap.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b1, 32'(1000 * (r + 1) + i));
            chk("wrap_count40", 64'(fifo_count), 64'(40));
            for (int i = 0; i < 40; i++) begin
                cyc(1'b0, 1'b1, 1'b0, 32'h0);
                chk("wrap_rd", 64'(rd_dat), 64'(1000 * (r + 1) + i));
            end
            chk("wrap_count0", 64'(fifo_count), 64'(0));
        end

        // Alternating write/read of complementary patterns.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] pat;
            pat = (i % 2 == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
            cyc(1'b0, 1'b1, 1'b1, pat);
            chk("alt_count1", 64'(fifo_count), 64'(1));
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            chk("alt_count0", 64'(fifo_count), 64'(0));
            chk("alt_rd", 64'(rd_dat), 64'(pat));
        end

        // Reset with ten words stored discards them.
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 32'(i + 77));
        chk("pre_rst_count", 64'(fifo_count), 64'(10));
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rst_count", 64'(fifo_count), 64'(0));
        chk("rst_empty", 64'(fifo_empty), 64'(1));
        cyc(1'b0, 1'b1, 1'b1, 32'hBEEF);
        chk("post_rst_count", 64'(fifo_count), 64'(1));

        // Random traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            logic r, c, w;
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 9) != 0);
            w = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 65 : 35));
            cyc(r, c, w, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameters SHALL be as follows:
- ADR_BIT, default 6, address width; depth DEPTH = 2**ADR_BIT (64).
- DAT_BIT, default 32, data word width.
- WEN_BIT, default 1, width of the cs_en and wr_en control vectors.
REQ-002 Ports SHALL be:
- clk  input  1  sole clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- cs_en  input  WEN_BIT  chip select, high active; an operation is requested when any bit is 1.
- wr_en  input  WEN_BIT  direction, high active; any bit 1 means write, all 0 means read.
- wr_dat  input  DAT_BIT  write data.
- rd_dat  output  DAT_BIT  registered read data.
- fifo_full  output  1  high when count equals DEPTH.
- fifo_empty  output  1  high when count equals 0.
- fifo_count  output  ADR_BIT+1  number of stored words, 0..DEPTH.

Function
REQ-003 Define push = |cs_en & |wr_en & ~fifo_full, and pop = |cs_en & ~|wr_en & ~fifo_empty.
- Push and pop are mutually exclusive by construction; the block has no simultaneous read and write.
REQ-004 On push, the block SHALL write wr_dat to mem[wptr], then wptr += 1 and count += 1 at the same edge.
REQ-005 On pop, the block SHALL load rd_dat with mem[rptr] at that edge, then rptr += 1 and count -= 1.
- Read latency is 1 clock: rd_dat is valid in the cycle after the pop request is sampled.
REQ-006 rd_dat SHALL hold its last value in any cycle without a pop.
REQ-007 A write request while fifo_full SHALL be ignored: no change to memory, pointers or count.
REQ-008 A read request while fifo_empty SHALL be ignored: rd_dat holds its value and no state changes.
REQ-009 With cs_en all-zero, the block SHALL be idle; wr_en and wr_dat are don't-care.
REQ-010 Pointer and wrap rules:
- Pointers are ADR_BIT bits wide and SHALL wrap from DEPTH-1 to 0.
- The count register is ADR_BIT+1 bits wide and never overflows or underflows.
REQ-011 Flag timing:
- fifo_full and fifo_empty SHALL be decoded combinationally from the count register.
- Both flags are therefore valid in the same cycle as the count update.
REQ-012 Data SHALL be delivered in strict FIFO order, including across pointer wrap.

Reset
REQ-013 While rst is high at a rising edge, the block SHALL clear wptr, rptr, count and rd_dat to 0.
- After reset: fifo_empty = 1, fifo_full = 0, fifo_count = 0.
REQ-014 Reset SHALL take priority over any concurrent push or pop.
- Memory contents are not cleared and are unspecified after reset.
REQ-015 Reset asserted mid-operation SHALL discard all stored words; the next edge after release accepts a new operation.

Structure
REQ-016 Package sync_fifo_pkg SHALL hold the default constants (ADR_BIT = 6, DAT_BIT = 32, WEN_BIT = 1) and the derived DEPTH.
REQ-017 Storage SHALL be a sub-module sync_fifo_mem:
- DEPTH x DAT_BIT, one write port and one read port, both synchronous.
- Pointers, count and flags remain in sync_fifo.
REQ-018 No latches; all registers SHALL be in a single clk domain.

Verification
REQ-019 Bench setup:
- Clock from tb_clk_gen with CLK_PERIOD 3.33 ns.
- rst held high for the first edges, then released.
REQ-020 Reset check: hold rst high -> fifo_empty = 1, fifo_full = 0, fifo_count = 0, rd_dat = 0.
REQ-021 Fill: write 0,1,2,... with cs_en = 1, wr_en = 1 -> count rises by 1 per edge; fifo_full = 1 after the 64th write (count = 64).
- A 65th write (value 64) is ignored and count stays 64.
REQ-022 Drain: cs_en = 1, wr_en = 0 for 64 cycles -> rd_dat = 0,1,...,63, each one cycle after its request.
- fifo_empty = 1 with count = 0 after the last pop.
- Further reads leave rd_dat = 63.
REQ-023 Wrap: write 40, read 40, write 40, read 40 -> data is returned in order across the pointer wrap, and count returns to 0.
REQ-024 Alternation and reset:
- Alternate write/read of 0xA5A5A5A5 and 0x5A5A5A5A -> count toggles between 1 and 0; rd_dat matches each written value.
- Assert rst with count = 10 -> count = 0, fifo_empty = 1 at the next edge.
